// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RV32 core: per-stage hold/bubble controls for
// load-use, EX redirects and user-confirmed IO reads, plus saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int CNT_W      = 32,
  parameter int IO_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       ID_rs1_addr,
  input  logic [4:0]       ID_rs2_addr,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             EX_MemRead,
  input  logic             EX_ioRead,
  input  logic [4:0]       EX_rd_addr,
  input  logic             EX_redirect,
  input  logic             MEM_ioRead,
  input  logic             io_ack,
  input  logic             clr_cnt,
  output logic             PC_Stall,
  output logic             IF_ID_Stall,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Stall,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Stall,
  output logic             MEM_WB_Flush,
  output logic             io_wait,
  output logic             io_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN     = 1'b0,
    IO_WAIT = 1'b1
  } state_t;

  // The wait counter only has to reach IO_TIMEOUT-1; one bit suffices when timeouts are off.
  localparam bit                TMO_EN    = (IO_TIMEOUT > 0);
  localparam int                WAIT_W    = (IO_TIMEOUT > 2) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TMO_EN ? IO_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              io_timeout_q, io_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic tmo;
  logic io_hold;
  logic redirect_act;
  logic load_use_act;

  // Hazard detection: x0 is never a real destination, so it never creates a dependency.
  always_comb begin
    ex_is_load = EX_MemRead | EX_ioRead;
    rs1_hit    = ID_uses_rs1 && (ID_rs1_addr == EX_rd_addr);
    rs2_hit    = ID_uses_rs2 && (ID_rs2_addr == EX_rd_addr);
    load_use   = ex_is_load && (EX_rd_addr != 5'd0) && (rs1_hit || rs2_hit);
  end

  always_comb begin
    tmo = TMO_EN && (state_q == IO_WAIT) && (wait_cnt_q == WAIT_LAST);
  end

  // Cause arbitration; everything is gated by rstn so reset forces a quiet pipeline.
  always_comb begin
    io_hold      = 1'b0;
    redirect_act = 1'b0;
    load_use_act = 1'b0;
    if (rstn) begin
      io_hold      = ((state_q == RUN) && MEM_ioRead && !io_ack) ||
                     ((state_q == IO_WAIT) && !io_ack && !tmo);
      redirect_act = !io_hold && EX_redirect;
      load_use_act = !io_hold && !EX_redirect && load_use;
    end
  end

  always_comb begin
    PC_Stall     = 1'b0;
    IF_ID_Stall  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Stall  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Stall = 1'b0;
    MEM_WB_Flush = 1'b0;
    if (io_hold) begin
      // Freeze everything upstream of MEM and keep a bubble flowing into WB.
      PC_Stall     = 1'b1;
      IF_ID_Stall  = 1'b1;
      ID_EX_Stall  = 1'b1;
      EX_MEM_Stall = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else if (redirect_act) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (load_use_act) begin
      PC_Stall     = 1'b1;
      IF_ID_Stall  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end
  end

  // IO wait FSM: an ack in the detection cycle means the data is already there, so no wait.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    io_timeout_d = io_timeout_q;
    case (state_q)
      RUN: begin
        if (MEM_ioRead && !io_ack) begin
          state_d    = IO_WAIT;
          wait_cnt_d = '0;
        end
      end
      IO_WAIT: begin
        if (io_ack) begin
          state_d = RUN;
        end else if (tmo) begin
          state_d      = RUN;
          io_timeout_d = 1'b1;
        end else if (TMO_EN && (wait_cnt_q != WAIT_LAST)) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Statistics saturate instead of wrapping so a long run never looks quiet.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (PC_Stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (redirect_act && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      io_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      io_timeout_q <= io_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign io_wait    = (state_q == IO_WAIT);
  assign io_timeout = io_timeout_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance without IO timeout, one with IO_TIMEOUT=3,
// both with 4-bit counters so saturation is reachable.
module tb_hazard_ctrl;

  localparam logic [6:0] CTL_NONE = 7'b0000000;
  localparam logic [6:0] CTL_LU   = 7'b1100100;
  localparam logic [6:0] CTL_RD   = 7'b0010100;
  localparam logic [6:0] CTL_IOH  = 7'b1101011;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] ID_rs1_addr, ID_rs2_addr, EX_rd_addr;
  logic       ID_uses_rs1, ID_uses_rs2, EX_MemRead, EX_ioRead;
  logic       EX_redirect, MEM_ioRead, io_ack, clr_cnt;

  logic       pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, memwb_f;
  logic       io_wait, io_timeout;
  logic [3:0] stall_cnt, flush_cnt;
  logic       pc_s_t, ifid_s_t, ifid_f_t, idex_s_t, idex_f_t, exmem_s_t, memwb_f_t;
  logic       io_wait_t, io_timeout_t;
  logic [3:0] stall_cnt_t, flush_cnt_t;

  logic [6:0] ctl, ctl_t;
  assign ctl   = {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, memwb_f};
  assign ctl_t = {pc_s_t, ifid_s_t, ifid_f_t, idex_s_t, idex_f_t, exmem_s_t, memwb_f_t};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(4), .IO_TIMEOUT(0)) dut (
    .clk(clk), .rstn(rstn),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_MemRead(EX_MemRead), .EX_ioRead(EX_ioRead), .EX_rd_addr(EX_rd_addr),
    .EX_redirect(EX_redirect), .MEM_ioRead(MEM_ioRead), .io_ack(io_ack), .clr_cnt(clr_cnt),
    .PC_Stall(pc_s), .IF_ID_Stall(ifid_s), .IF_ID_Flush(ifid_f),
    .ID_EX_Stall(idex_s), .ID_EX_Flush(idex_f), .EX_MEM_Stall(exmem_s), .MEM_WB_Flush(memwb_f),
    .io_wait(io_wait), .io_timeout(io_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4), .IO_TIMEOUT(3)) dut_tmo (
    .clk(clk), .rstn(rstn),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_MemRead(EX_MemRead), .EX_ioRead(EX_ioRead), .EX_rd_addr(EX_rd_addr),
    .EX_redirect(EX_redirect), .MEM_ioRead(MEM_ioRead), .io_ack(io_ack), .clr_cnt(clr_cnt),
    .PC_Stall(pc_s_t), .IF_ID_Stall(ifid_s_t), .IF_ID_Flush(ifid_f_t),
    .ID_EX_Stall(idex_s_t), .ID_EX_Flush(idex_f_t), .EX_MEM_Stall(exmem_s_t),
    .MEM_WB_Flush(memwb_f_t),
    .io_wait(io_wait_t), .io_timeout(io_timeout_t), .stall_cnt(stall_cnt_t),
    .flush_cnt(flush_cnt_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    ID_rs1_addr = 5'd0; ID_rs2_addr = 5'd0; EX_rd_addr = 5'd0;
    ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
    EX_MemRead  = 1'b0; EX_ioRead   = 1'b0;
    EX_redirect = 1'b0; MEM_ioRead  = 1'b0;
    io_ack      = 1'b0; clr_cnt     = 1'b0;
  endtask

  task automatic set_lu(input logic mem, input logic io, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    EX_MemRead  = mem; EX_ioRead = io; EX_rd_addr = rd;
    ID_rs1_addr = rs1; ID_uses_rs1 = u1;
    ID_rs2_addr = rs2; ID_uses_rs2 = u2;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    // Live hazard inputs during reset must not reach the pipeline.
    EX_redirect = 1'b1;
    MEM_ioRead  = 1'b1;
    settle();
    check("rst_ctl_quiet", 32'(ctl), 32'(CTL_NONE));
    tick();
    tick();
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst_io_wait", 32'(io_wait), 32'd0);
    check("rst_io_timeout", 32'(io_timeout_t), 32'd0);
    idle();
    rstn = 1'b1;
    settle();
    check("idle_ctl", 32'(ctl), 32'(CTL_NONE));

    // lw x5 ; add x6,x5,x1
    set_lu(1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
    settle();
    check("lu_rs1_ctl", 32'(ctl), 32'(CTL_LU));
    tick();
    idle();
    settle();
    check("lu_one_bubble", 32'(ctl), 32'(CTL_NONE));
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    set_lu(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    settle();
    check("lu_x0_ctl", 32'(ctl), 32'(CTL_NONE));
    set_lu(1'b1, 1'b0, 5'd5, 5'd3, 1'b1, 5'd5, 1'b0);
    settle();
    check("lu_rs2_unused_ctl", 32'(ctl), 32'(CTL_NONE));
    set_lu(1'b0, 1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
    settle();
    check("nonload_ctl", 32'(ctl), 32'(CTL_NONE));
    set_lu(1'b0, 1'b1, 5'd7, 5'd2, 1'b1, 5'd7, 1'b1);
    settle();
    check("lu_io_rs2_ctl", 32'(ctl), 32'(CTL_LU));
    tick();
    check("lu_io_stall_cnt", 32'(stall_cnt), 32'd2);

    // Redirect outranks a simultaneous load-use.
    set_lu(1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    EX_redirect = 1'b1;
    settle();
    check("redirect_ctl", 32'(ctl), 32'(CTL_RD));
    tick();
    idle();
    settle();
    check("redirect_flush_cnt", 32'(flush_cnt), 32'd1);
    check("redirect_stall_cnt", 32'(stall_cnt), 32'd2);

    // IO read confirmed on the 5th cycle; redirect during the hold is ignored.
    MEM_ioRead  = 1'b1;
    EX_redirect = 1'b1;
    settle();
    check("io_c1_ctl", 32'(ctl), 32'(CTL_IOH));
    check("io_c1_wait", 32'(io_wait), 32'd0);
    tick();
    for (int c = 2; c <= 4; c++) begin
      MEM_ioRead = 1'b0;
      settle();
      check($sformatf("io_c%0d_ctl", c), 32'(ctl), 32'(CTL_IOH));
      check($sformatf("io_c%0d_wait", c), 32'(io_wait), 32'd1);
      tick();
    end
    EX_redirect = 1'b0;
    io_ack      = 1'b1;
    settle();
    check("io_c5_ack_ctl", 32'(ctl), 32'(CTL_NONE));
    check("io_c5_wait", 32'(io_wait), 32'd1);
    tick();
    idle();
    settle();
    check("io_release_wait", 32'(io_wait), 32'd0);
    check("io_stall_cnt", 32'(stall_cnt), 32'd6);
    check("io_flush_cnt", 32'(flush_cnt), 32'd1);

    // Ack in the detection cycle: no wait at all.
    MEM_ioRead = 1'b1;
    io_ack     = 1'b1;
    settle();
    check("io_fast_ack_ctl", 32'(ctl), 32'(CTL_NONE));
    tick();
    idle();
    settle();
    check("io_fast_ack_wait", 32'(io_wait), 32'd0);

    // Reset while waiting on IO.
    MEM_ioRead = 1'b1;
    tick();
    MEM_ioRead = 1'b0;
    tick();
    check("io_wait_before_rst", 32'(io_wait), 32'd1);
    rstn = 1'b0;
    settle();
    check("rst_in_wait_ctl", 32'(ctl), 32'(CTL_NONE));
    tick();
    check("rst_in_wait_state", 32'(io_wait), 32'd0);
    check("rst_in_wait_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_in_wait_flush_cnt", 32'(flush_cnt), 32'd0);
    rstn = 1'b1;

    // Timeout on the IO_TIMEOUT=3 instance; the other instance keeps waiting.
    MEM_ioRead = 1'b1;
    settle();
    check("tmo_c1_ctl", 32'(ctl_t), 32'(CTL_IOH));
    tick();
    MEM_ioRead = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      settle();
      check($sformatf("tmo_c%0d_ctl", c), 32'(ctl_t), 32'(CTL_IOH));
      tick();
    end
    settle();
    check("tmo_c4_release_ctl", 32'(ctl_t), 32'(CTL_NONE));
    check("tmo_c4_not_yet_sticky", 32'(io_timeout_t), 32'd0);
    check("notmo_c4_ctl", 32'(ctl), 32'(CTL_IOH));
    tick();
    check("tmo_sticky", 32'(io_timeout_t), 32'd1);
    check("tmo_back_to_run", 32'(io_wait_t), 32'd0);
    check("notmo_still_wait", 32'(io_wait), 32'd1);
    check("tmo_stall_cnt", 32'(stall_cnt_t), 32'd3);
    tick();
    io_ack = 1'b1;
    settle();
    check("notmo_ack_ctl", 32'(ctl), 32'(CTL_NONE));
    tick();
    idle();
    settle();
    check("notmo_stall_cnt", 32'(stall_cnt), 32'd5);
    check("notmo_no_timeout", 32'(io_timeout), 32'd0);

    // Counter clear and saturation.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    set_lu(1'b1, 1'b0, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    check("sat_stall_reach", 32'(stall_cnt), 32'd15);
    for (int i = 0; i < 3; i++) tick();
    check("sat_stall_hold", 32'(stall_cnt), 32'd15);
    clr_cnt = 1'b1;
    tick();
    check("clr_beats_stall", 32'(stall_cnt), 32'd0);
    idle();
    EX_redirect = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check("sat_flush_hold", 32'(flush_cnt), 32'd15);
    idle();
    tick();
    check("tmo_still_sticky", 32'(io_timeout_t), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
